keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 100000: number of clk cycles each column is driven.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: number of consecutive identical full scans required for press or release.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port row, input, 4: keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col, output, 4: keypad column drive, active-low one-hot.
REQ-007 SHALL have port key_code, output, 4: hex code of the debounced key.
REQ-008 SHALL have port key_valid, output, 1: key_code holds an unconsumed key.
REQ-009 SHALL have port key_ready, input, 1: consumer accepts the key.
REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when a key is dropped.
REQ-011 SHALL have port value, output, 32: decimal accumulator for the display driver.

Function
REQ-012 SHALL pass row through a 2-flop synchronizer before any use.
REQ-013 SHALL hold col = ~(4'b0001 << c) for column index c = 0..3; c advances every SCAN_TICKS cycles and wraps 3 -> 0.
REQ-014 SHALL sample the synchronized row on the last cycle of each column window.
REQ-015 SHALL classify each full 4-column scan as NONE, SINGLE(code), or MULTI; MULTI SHALL be treated as NONE.
REQ-016 SHALL map (row r, col c) to codes: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D, with c0..c3 in that order.
REQ-017 SHALL implement FSM IDLE -> DEBOUNCE on a SINGLE scan; DEBOUNCE -> IDLE on NONE or a different code; DEBOUNCE -> HELD after DEBOUNCE_SCANS equal SINGLE scans (emit); HELD -> IDLE after DEBOUNCE_SCANS consecutive NONE scans.
REQ-018 SHALL emit a key on the cycle after the scan that completes debounce: key_code loaded, key_valid = 1.
REQ-019 SHALL hold key_valid and key_code stable until a cycle with key_valid && key_ready; key_valid SHALL clear on the next cycle.
REQ-020 SHALL, on an emit while key_valid is 1 and key_ready is 0, keep the old key and pulse overrun for one cycle; an emit coincident with a handshake SHALL load the new key with no overrun.
REQ-021 SHALL produce one emit per press; a held key SHALL never repeat.
REQ-022 SHALL update value only on a handshake cycle, effective the next cycle: digit d (0-9) -> (value*10 + d) mod 10000; C -> 0; B -> value/10; other codes -> unchanged.

Reset
REQ-023 SHALL, on rst, set col = 4'b1110, c = 0, tick counter = 0, FSM = IDLE, key_code = 0, key_valid = 0, overrun = 0, value = 0, and synchronizer flops = 4'b1111.
REQ-024 SHALL, on rst asserted mid-debounce or mid-hold, discard all progress; a key still held after reset SHALL emit after DEBOUNCE_SCANS full scans.

Configuration
REQ-025 SHALL, with macro KEYPAD_SCAN_ACCUM_EN defined, implement the accumulator of REQ-022.
REQ-026 SHALL, without KEYPAD_SCAN_ACCUM_EN, tie value to 32'd0 and infer no accumulator logic; all other behaviour SHALL be unchanged.

Structure
REQ-027 SHALL take the FSM state enum, the 4x4 key-code table, and the clear (C) and backspace (B) code constants from shared package keypad_pkg.
REQ-028 SHALL place the synchronizer in sub-module sync2 (4 bits wide); all other logic SHALL be in keypad_scan.

Verification (SCAN_TICKS=8, DEBOUNCE_SCANS=2)
REQ-029 SHALL verify: after reset with no key -> col cycles 1110, 1101, 1011, 0111 at 8 cycles each, key_valid stays 0.
REQ-030 SHALL verify: row0 low while col0 is driven, for 3 scans, key_ready=1 -> exactly one key_valid with key_code=1; value=1 if ACCUM_EN is defined.
REQ-031 SHALL verify: a 1-scan glitch on row2/col1 -> no emit.
REQ-032 SHALL verify: keys 4 then 2 pressed and released with key_ready=0 throughout -> key_code stays 4, overrun pulses once.
REQ-033 SHALL verify: key sequence 9,8,7,6,5 accepted -> value=8765; then B -> 876; then C -> 0.
REQ-034 SHALL verify: two keys in different columns held simultaneously -> no emit; rst during DEBOUNCE -> outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   key_state_t : debounce FSM states (idle, debouncing a candidate, key held)
//   KEY_TABLE   : hex code for each (row, col) position, indexed [row][col]
//   KEY_CLEAR   : code that clears the decimal accumulator
//   KEY_BACK    : code that removes the last decimal digit
//   key_lookup  : helper returning KEY_TABLE[row][col]
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } key_state_t;

  // Packed so that KEY_TABLE[r][c] picks row r, column c. Rows are listed
  // from row 3 down to row 0, and within a row from column 3 down to column 0.
  localparam logic [3:0][3:0][3:0] KEY_TABLE = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3: c3..c0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_BACK  = 4'hB;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[r][c];
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bus of independent, slowly changing bits.
// Both stages reset to all-ones, the idle level of the active-low keypad rows.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input bus
//   q   : synchronized output bus
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce, a one-entry output register and an
// optional decimal accumulator.
//
// Optional feature: define KEYPAD_SCAN_ACCUM_EN to build the accumulator that
// drives 'value'; otherwise 'value' is tied to zero.
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   row[3:0]   : keypad rows, active-low, asynchronous to clk
//   col[3:0]   : column drive, active-low one-hot
//   key_code   : hex code of the debounced key
//   key_valid  : key_code holds an unconsumed key
//   key_ready  : consumer accepts the key
//   overrun    : one-cycle pulse when a new key was dropped
//   value      : decimal accumulator (0..9999) for the display driver
//   state_dbg  : current debounce FSM state
//
// Handshake: key_valid/key_code stay stable while key_valid is high and
// key_ready is low. A transfer happens on any cycle with key_valid && key_ready;
// key_valid drops on the following cycle unless a new key is loaded on that
// same cycle. A new key arriving while an untransferred key is waiting is
// dropped and reported on overrun.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        overrun,
  output logic [31:0] value,
  output key_state_t  state_dbg
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  // ---------------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] row_s;

  sync2 #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  // ---------------------------------------------------------------------------
  // Column timing
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick;
  logic [1:0]    col_idx;
  logic          last_tick;

  assign last_tick = (tick == TW'(SCAN_TICKS - 1));
  assign col       = ~(4'b0001 << col_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick    <= '0;
      col_idx <= 2'd0;
    end else if (last_tick) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan classification. scan_hits counts pressed keys seen so far in the
  // current scan, saturating at 2 (MULTI). The current column's sample is
  // merged combinationally so the verdict is ready on the scan's last cycle.
  // ---------------------------------------------------------------------------
  logic [1:0] scan_hits;
  logic [3:0] scan_code;
  logic [1:0] col_hits;
  logic [3:0] col_code;
  logic [2:0] hit_sum;
  logic [1:0] tot_hits;
  logic [3:0] merged_code;
  logic       scan_done;
  logic       scan_single;

  always_comb begin
    col_hits = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = key_lookup(2'(r), col_idx);
      end
    end
  end

  assign hit_sum     = {1'b0, scan_hits} + {1'b0, col_hits};
  assign tot_hits    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign merged_code = (col_hits != 2'd0) ? col_code : scan_code;
  assign scan_done   = last_tick && (col_idx == 2'd3);
  assign scan_single = scan_done && (tot_hits == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_hits <= 2'd0;
      scan_code <= 4'h0;
    end else if (last_tick) begin
      if (col_idx == 2'd3) begin
        scan_hits <= 2'd0;
        scan_code <= 4'h0;
      end else begin
        scan_hits <= tot_hits;
        scan_code <= merged_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM. db_cnt counts equal SINGLE scans in DEBOUNCE and
  // consecutive NONE scans in HELD. MULTI scans count as NONE.
  // ---------------------------------------------------------------------------
  key_state_t    state, state_n;
  logic [3:0]    cand, cand_n;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic          emit;
  logic [3:0]    emit_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cand   <= 4'h0;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      db_cnt <= db_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    db_cnt_n  = db_cnt;
    emit      = 1'b0;
    emit_code = cand;
    case (state)
      ST_IDLE: begin
        if (scan_single) begin
          cand_n = merged_code;
          if (DEBOUNCE_SCANS <= 1) begin
            emit      = 1'b1;
            emit_code = merged_code;
            state_n   = ST_HELD;
            db_cnt_n  = '0;
          end else begin
            state_n  = ST_DEBOUNCE;
            db_cnt_n = DW'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (scan_done) begin
          if (scan_single && (merged_code == cand)) begin
            if (db_cnt >= DW'(DEBOUNCE_SCANS - 1)) begin
              emit     = 1'b1;
              state_n  = ST_HELD;
              db_cnt_n = '0;
            end else begin
              db_cnt_n = db_cnt + DW'(1);
            end
          end else begin
            state_n  = ST_IDLE;
            db_cnt_n = '0;
          end
        end
      end
      ST_HELD: begin
        if (scan_done) begin
          if (scan_single) begin
            db_cnt_n = '0;
          end else if (db_cnt >= DW'(DEBOUNCE_SCANS - 1)) begin
            state_n  = ST_IDLE;
            db_cnt_n = '0;
          end else begin
            db_cnt_n = db_cnt + DW'(1);
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        db_cnt_n = '0;
      end
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic hs;
  assign hs = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (key_valid && !key_ready) begin
          overrun <= 1'b1;
        end else begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
        end
      end else if (hs) begin
        key_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decimal accumulator, updated only by transferred keys
  // ---------------------------------------------------------------------------
`ifdef KEYPAD_SCAN_ACCUM_EN
  logic [13:0] acc, acc_n;

  always_comb begin
    acc_n = acc;
    if (key_code <= 4'd9) begin
      acc_n = 14'(((32'(acc) * 32'd10) + 32'(key_code)) % 32'd10000);
    end else if (key_code == KEY_CLEAR) begin
      acc_n = 14'd0;
    end else if (key_code == KEY_BACK) begin
      acc_n = acc / 14'd10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= 14'd0;
    else if (hs) acc <= acc_n;
  end

  assign value = 32'(acc);
`else
  assign value = 32'd0;
`endif

endmodule
